// File: rtl/decode_sched_if.sv
// rtl/decode_sched_if.sv - requester, coefficient and decoder-side signals of the ByteDecode scheduler
interface decode_sched_if;
   logic        i_req0, i_req1;
   logic [3:0]  i_l0, i_l1;
   logic [2:0]  i_npoly0, i_npoly1;
   logic [63:0] i_ibytes0, i_ibytes1;
   logic        i_ibytes_valid0, i_ibytes_valid1;
   logic        o_ibytes_ready0, o_ibytes_ready1;
   logic        o_gnt0, o_gnt1;
   logic [63:0] o_coeffs;
   logic        o_coeffs_valid0, o_coeffs_valid1;
   logic [1:0]  o_poly_idx;
   logic        o_done0, o_done1;
   logic        o_err0, o_err1;
   logic [63:0] o_dec_ibytes;
   logic        o_dec_ibytes_valid;
   logic [3:0]  o_dec_l;
   logic        i_dec_ibytes_ready;
   logic [63:0] i_dec_coeffs;
   logic        i_dec_coeffs_valid;
   logic        i_dec_done;

   modport slave (
      input  i_req0, i_req1, i_l0, i_l1, i_npoly0, i_npoly1,
      input  i_ibytes0, i_ibytes1, i_ibytes_valid0, i_ibytes_valid1,
      output o_ibytes_ready0, o_ibytes_ready1, o_gnt0, o_gnt1,
      output o_coeffs, o_coeffs_valid0, o_coeffs_valid1, o_poly_idx,
      output o_done0, o_done1, o_err0, o_err1,
      output o_dec_ibytes, o_dec_ibytes_valid, o_dec_l,
      input  i_dec_ibytes_ready, i_dec_coeffs, i_dec_coeffs_valid, i_dec_done
   );

   modport master (
      output i_req0, i_req1, i_l0, i_l1, i_npoly0, i_npoly1,
      output i_ibytes0, i_ibytes1, i_ibytes_valid0, i_ibytes_valid1,
      input  o_ibytes_ready0, o_ibytes_ready1, o_gnt0, o_gnt1,
      input  o_coeffs, o_coeffs_valid0, o_coeffs_valid1, o_poly_idx,
      input  o_done0, o_done1, o_err0, o_err1,
      input  o_dec_ibytes, o_dec_ibytes_valid, o_dec_l,
      output i_dec_ibytes_ready, i_dec_coeffs, i_dec_coeffs_valid, i_dec_done
   );
endinterface

// File: rtl/decode_sched.sv
// rtl/decode_sched.sv - round-robin scheduler sharing one ByteDecode_l unit between two requesters
module decode_sched #(
   parameter int NREQ_W    = 1,
   parameter int NPOLY_MAX = 4
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   decode_sched_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_FIN} state_t;

   state_t            state_q, state_d;
   logic [NREQ_W-1:0] owner_q, rr_q, pick;
   logic [3:0]        l_q, pick_l;
   logic [2:0]        npoly_q, pick_np;
   logic [1:0]        poly_q;
   logic [5:0]        wcnt_q, wlast;
   logic              err_q;
   logic              any_req, pick_ok, own_valid, accept, last_word, poly_last;

   assign any_req = bus.i_req0 | bus.i_req1;
   assign pick    = (bus.i_req0 & bus.i_req1) ? rr_q : NREQ_W'(bus.i_req1);
   assign pick_l  = pick[0] ? bus.i_l1 : bus.i_l0;
   assign pick_np = pick[0] ? bus.i_npoly1 : bus.i_npoly0;
   assign pick_ok = (pick_l inside {4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12}) &&
                    (pick_np != 3'd0) && (pick_np <= 3'(NPOLY_MAX));

   // Each polynomial consumes exactly 4*l words; wlast is the index of the final one.
   assign own_valid = owner_q[0] ? bus.i_ibytes_valid1 : bus.i_ibytes_valid0;
   assign accept    = (state_q == S_FEED) && own_valid && bus.i_dec_ibytes_ready;
   assign wlast     = {l_q - 4'd1, 2'b11};
   assign last_word = accept && (wcnt_q == wlast);
   assign poly_last = ({1'b0, poly_q} == (npoly_q - 3'd1));

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_req) state_d = pick_ok ? S_FEED : S_FIN;
         S_FEED: begin
            if (bus.i_dec_done)  state_d = S_FIN;
            else if (last_word)  state_d = S_DRAIN;
         end
         S_DRAIN: if (bus.i_dec_done) state_d = poly_last ? S_FIN : S_FEED;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         owner_q <= '0;
         rr_q    <= '0;
         l_q     <= '0;
         npoly_q <= '0;
         poly_q  <= '0;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (any_req) begin
               owner_q <= pick;
               l_q     <= pick_l;
               npoly_q <= pick_np;
               poly_q  <= '0;
               wcnt_q  <= '0;
               err_q   <= !pick_ok;
            end
            S_FEED: begin
               if (bus.i_dec_done) err_q  <= 1'b1;
               else if (accept)    wcnt_q <= wcnt_q + 6'd1;
            end
            S_DRAIN: if (bus.i_dec_done && !poly_last) begin
               poly_q <= poly_q + 2'd1;
               wcnt_q <= '0;
            end
            S_FIN: begin
               rr_q    <= ~owner_q;
               l_q     <= '0;
               npoly_q <= '0;
               poly_q  <= '0;
               wcnt_q  <= '0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.o_gnt0             = (state_q != S_IDLE) && !owner_q[0];
      bus.o_gnt1             = (state_q != S_IDLE) &&  owner_q[0];
      bus.o_dec_ibytes       = '0;
      bus.o_dec_ibytes_valid = 1'b0;
      bus.o_ibytes_ready0    = 1'b0;
      bus.o_ibytes_ready1    = 1'b0;
      bus.o_coeffs_valid0    = 1'b0;
      bus.o_coeffs_valid1    = 1'b0;
      bus.o_done0            = 1'b0;
      bus.o_done1            = 1'b0;
      bus.o_err0             = 1'b0;
      bus.o_err1             = 1'b0;
      bus.o_coeffs           = bus.i_dec_coeffs;
      bus.o_dec_l            = l_q;
      bus.o_poly_idx         = poly_q;
      if (state_q == S_FEED) begin
         bus.o_dec_ibytes       = owner_q[0] ? bus.i_ibytes1 : bus.i_ibytes0;
         bus.o_dec_ibytes_valid = own_valid;
         bus.o_ibytes_ready0    = !owner_q[0] && bus.i_dec_ibytes_ready;
         bus.o_ibytes_ready1    =  owner_q[0] && bus.i_dec_ibytes_ready;
      end
      if (state_q == S_FEED || state_q == S_DRAIN) begin
         bus.o_coeffs_valid0 = bus.i_dec_coeffs_valid && !owner_q[0];
         bus.o_coeffs_valid1 = bus.i_dec_coeffs_valid &&  owner_q[0];
      end
      if (state_q == S_FIN) begin
         bus.o_done0 = !owner_q[0];
         bus.o_done1 =  owner_q[0];
         bus.o_err0  = !owner_q[0] && err_q;
         bus.o_err1  =  owner_q[0] && err_q;
      end
   end

endmodule

// File: doc/decode_sched.md
Name: decode_sched

Overview:
Two-requester scheduler for one shared Kyber ByteDecode_l unit (`decode`).
- Requester 0 (public-key / dv path) and requester 1 (ciphertext du path) each ask for a vector of 1..4 polynomials at a given bit width l.
- The block arbitrates round-robin and streams each requester's 64-bit byte words into the decoder, exactly 4*l words per polynomial.
- It waits for the decoder's per-polynomial done, routes returned coefficient words to the owner, and signals completion.

Parameters:
NREQ_W, 1, requester index width (fixed two requesters)
NPOLY_MAX, 4, max polynomials per request (Kyber k)

Ports:
i_clk  in  1  clock
i_rstn  in  1  async active-low reset
i_req0 / i_req1  in  1  request; held high until matching o_done pulse
i_l0 / i_l1  in  4  coefficient bit width l for the request
i_npoly0 / i_npoly1  in  3  polynomial count, 1..4
i_ibytes0 / i_ibytes1  in  64  byte-stream word from requester
i_ibytes_valid0 / i_ibytes_valid1  in  1  word valid
o_ibytes_ready0 / o_ibytes_ready1  out  1  word accepted this cycle when valid&ready
o_gnt0 / o_gnt1  out  1  requester owns decoder (IDLE excluded)
o_coeffs  out  64  coefficient word from decoder (pass-through)
o_coeffs_valid0 / o_coeffs_valid1  out  1  coefficient word valid, owner only
o_poly_idx  out  2  index of polynomial currently decoding
o_done0 / o_done1  out  1  one-cycle pulse: request complete
o_err0 / o_err1  out  1  one-cycle pulse with o_done: request rejected/aborted
o_dec_ibytes  out  64  to decoder i_ibytes
o_dec_ibytes_valid  out  1  to decoder i_ibytes_valid
o_dec_l  out  4  to decoder i_l, latched l
i_dec_ibytes_ready  in  1  from decoder o_ibytes_ready
i_dec_coeffs  in  64  from decoder o_coeffs
i_dec_coeffs_valid  in  1  from decoder o_coeffs_valid
i_dec_done  in  1  from decoder o_done, per polynomial

Behaviour:
Reset (async, i_rstn=0):
- State=IDLE; all outputs 0; rr pointer=0.
- Word count, poly count, latched l/npoly/owner cleared.
- Asserting reset mid-operation aborts immediately. No done pulse.

States: IDLE, FEED, DRAIN, FIN.

IDLE:
- Both req high: grant to the rr pointer side. Otherwise grant to the one requesting.
- On grant: latch owner, l, npoly; poly_cnt=0; wcnt=0.
- Next cycle: FEED if l∈{1,4,5,10,11,12} and npoly∈1..4. Otherwise FIN with err flag set.
- o_gnt asserted from the cycle after the request is seen.

FEED:
- o_dec_ibytes = owner's i_ibytes.
- o_dec_ibytes_valid = owner's i_ibytes_valid.
- Owner's o_ibytes_ready = i_dec_ibytes_ready. Non-owner ready stays 0.
- Each accepted word (valid&ready) increments wcnt.
- On acceptance of word 4*l-1 (e.g. 47 for l=12, 3 for l=1): go to DRAIN; valid drops next cycle.
- No word beyond 4*l is ever forwarded.

DRAIN:
- o_dec_ibytes_valid=0, all ready=0.
- On i_dec_done: if poly_cnt==npoly-1, go to FIN. Else poly_cnt++, wcnt=0, go to FEED.

FIN (one cycle):
- Pulse owner's o_done, plus o_err if err flag set.
- Set rr pointer to the non-owner; drop o_gnt; return to IDLE.
- The same requester may be re-granted no earlier than the cycle after FIN.

Coefficient routing:
- o_coeffs = i_dec_coeffs always.
- o_coeffs_validX = i_dec_coeffs_valid & gntX, in FEED or DRAIN.
- Coeff valid outside FEED/DRAIN is dropped.

Protocol error:
- i_dec_done during FEED, before all words are sent: go to FIN with err.
- The decoder is expected to drop valid on done, so it is left to self-clear.

Other rules:
- o_dec_l = latched l, held stable through FEED and DRAIN; 0 in IDLE.
- o_poly_idx = poly_cnt.
- Requests dropped mid-operation are ignored; completion proceeds normally.

Test Plan:
1. req0 only, l=12, npoly=2, ready always 1, decoder done 3 cycles after last word -> 48 words forwarded per poly; o_poly_idx 0 then 1; one o_done0 pulse, o_err0=0.
2. req0 and req1 raised the same cycle after reset -> req0 served first (ptr=0). req1 granted the cycle after FIN; o_dec_l switches from l0=4 to l1=10.
3. req0 re-asserted immediately after its done while req1 pending -> req1 wins (rr). Then req0 is served.
4. i_dec_ibytes_ready toggled 1010…, valid gaps from requester, l=5 -> exactly 20 accepted words per poly; non-owner ready stays 0; coeff valid only on owner's port.
5. req1 with l=3 (or npoly=0) -> o_done1 and o_err1 pulse 2 cycles after req; o_dec_ibytes_valid never asserted.
6. i_rstn low mid-FEED (word 10 of 44) -> all outputs 0 immediately, IDLE. A fresh request afterwards starts from wcnt=0 with no done pulse for the aborted request.
